usbh_nes_joypad_serializer: RTL and testbench
=============================================

Name: usbh_nes_joypad_serializer

Overview:
Downstream stage of the USB HID report decoder. It takes the 8-bit NES button vector from the decoder, synchronises and debounces it, and presents it to the NES core as a 4021-style serial joypad. The CPU side drives a strobe level from the $4016 write and a one-cycle read pulse for each $4016 read. The block sits between the USB host report path and the NES APU/IO register block.

Parameters:
c_debounce_cycles, 64, number of consecutive i_clk cycles the synchronised button vector must stay unchanged before it is accepted (minimum 1).
c_fill_bit, 1, value shifted into the MSB on each read; bit returned after all 8 buttons have been read.

Ports:
i_clk  input  1  system clock (same domain as NES CPU register access)
i_reset  input  1  reset; one clock; reset is asynchronous and active-high
i_btn  input  8  button vector {R,L,D,U,Start,Select,B,A}, 1 = pressed; may change at any cycle
i_strobe  input  1  joypad strobe level ($4016 bit0 latch)
i_read  input  1  one-cycle pulse per CPU read of this joypad port
o_data  output  1  serial button bit presented to CPU, 1 = pressed
o_btn_stable  output  8  debounced button vector (after optional D-pad cleanup)
o_read_count  output  4  number of shifts since the last strobe, saturates at 8

Behaviour:
- Reset (async assert, sync release): sync stages, candidate, o_btn_stable, shift register, o_read_count and debounce counter all = 0; o_data = 0.
- Synchroniser: 2-flop chain on i_btn (s1 -> s2); the debouncer sees s2 only.
- Debounce: register cand, counter cnt of width $clog2(c_debounce_cycles+1).
  - s2 != cand: cand <= s2, cnt <= 0.
  - Else if cnt == c_debounce_cycles - 1: stable <= cand, cnt holds.
  - Else cnt++.
  - i_btn change to o_btn_stable update = 2 + c_debounce_cycles + 1 cycles. A glitch shorter than c_debounce_cycles never reaches stable.
- Load value L = stable after optional D-pad cleanup; o_btn_stable = L.
- Shift register sr[7:0]; o_data = sr[0] (registered, no combinational path from inputs).
- i_strobe = 1: every cycle sr <= L and o_read_count <= 0. i_read is ignored for shifting, so o_data continuously tracks A.
- i_strobe = 0 with i_read = 1:
  - sr <= {c_fill_bit, sr[7:1]}.
  - o_read_count <= min(o_read_count + 1, 8).
  - The CPU samples o_data in the read cycle, and the new bit appears next cycle.
- i_strobe = 0 with i_read = 0: sr holds. Button changes after the strobe falls are invisible until the next strobe.
- Read order:
  - Reads 1..8 return A, B, Select, Start, Up, Down, Left, Right.
  - Reads 9 and later return c_fill_bit indefinitely; o_read_count stays at 8.
- Strobe falling edge: sr keeps the value loaded in the last strobe-high cycle; no extra load.
- Simultaneous i_strobe = 1 and i_read = 1: strobe wins (reload, count = 0).
- Reset mid-sequence: all state cleared immediately. The first reads after reset return 0 until a strobe loads L.

Optional Feature:
JOYPAD_DPAD_CLEAN_EN
- Defined:
  - If L-candidate bits U and D are both 1, both are forced to 0.
  - Likewise for L and R.
  - Applied between stable and L, so it shows on o_btn_stable and in the serial data.
  - This prevents impossible D-pad states, e.g. the upstream all-directions chord from A+B+Start+Select.
- Undefined: L = stable unchanged.

Test Plan:
- Reset, then hold i_btn = 8'h00 with no strobe -> o_data = 0, o_read_count = 0, o_btn_stable = 0.
- Set i_btn = 8'b0000_1001 (A, Start), wait 70 cycles, pulse strobe high then low, issue 10 reads -> o_data sequence 1,0,0,1,0,0,0,0,1,1; o_read_count ends at 8.
- With c_debounce_cycles = 64, toggle i_btn bit1 for 10 cycles -> o_btn_stable never changes. Hold it for 100 cycles -> o_btn_stable[1] = 1 exactly 67 cycles after the i_btn change.
- Hold i_strobe = 1 and pulse i_read 3 times with i_btn A = 1 -> o_data stays 1 and o_read_count stays 0. Assert strobe and read in the same cycle mid-sequence -> reload and count = 0.
- After 4 reads, change i_btn and wait for it to debounce, then do 4 more reads -> the remaining bits reflect the old latched value. Assert i_reset during read 5 -> o_data = 0 and count = 0 asynchronously.
- i_btn = 8'hF0 stable, strobe, 8 reads -> bits 5..8 = 0,0,0,0 with JOYPAD_DPAD_CLEAN_EN; 1,1,1,1 without it.

Source files
------------

// File: rtl/usbh_nes_joypad_serializer.sv
// 4021-style NES joypad: synchronises and debounces the decoded HID button vector, then serialises it on $4016 reads.
// Optional D-pad cleanup (opposing directions cancel) is enabled by defining JOYPAD_DPAD_CLEAN_EN.
module usbh_nes_joypad_serializer #(
    parameter int   c_debounce_cycles = 64,
    parameter logic c_fill_bit        = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_btn,
    input  logic       i_strobe,
    input  logic       i_read,
    output logic       o_data,
    output logic [7:0] o_btn_stable,
    output logic [3:0] o_read_count
);

    localparam int              CNT_W    = $clog2(c_debounce_cycles + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(c_debounce_cycles - 1);

    logic [7:0]       sync_p1;
    logic [7:0]       sync_p2;
    logic [7:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       stable;
    logic [7:0]       load_val;
    logic [7:0]       sr;
    logic [3:0]       read_count;

    function automatic logic [7:0] dpad_clean(input logic [7:0] b);
        logic [7:0] r;
        r = b;
`ifdef JOYPAD_DPAD_CLEAN_EN
        if (b[4] && b[5]) begin
            r[4] = 1'b0;
            r[5] = 1'b0;
        end
        if (b[6] && b[7]) begin
            r[6] = 1'b0;
            r[7] = 1'b0;
        end
`endif
        return r;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= 4'd8) ? 4'd8 : v + 4'd1;
    endfunction

    // Stage p1/p2: two-flop synchroniser, then debounce against the held candidate
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_p1 <= '0;
            sync_p2 <= '0;
            cand    <= '0;
            cnt     <= '0;
            stable  <= '0;
        end else begin
            sync_p1 <= i_btn;
            sync_p2 <= sync_p1;
            if (sync_p2 != cand) begin
                cand <= sync_p2;
                cnt  <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= cand;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign load_val     = dpad_clean(stable);
    assign o_btn_stable = load_val;

    // Shift stage: strobe level reloads every cycle and takes priority over a read
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sr         <= '0;
            read_count <= '0;
        end else if (i_strobe) begin
            sr         <= load_val;
            read_count <= '0;
        end else if (i_read) begin
            sr         <= {c_fill_bit, sr[7:1]};
            read_count <= sat_inc(read_count);
        end
    end

    assign o_data       = sr[0];
    assign o_read_count = read_count;

endmodule

// File: tb/tb_usbh_nes_joypad_serializer.sv
// Randomised and directed bench for usbh_nes_joypad_serializer against a window/queue-level reference model.
module tb_usbh_nes_joypad_serializer;

    localparam int   DEB  = 64;
    localparam logic FILL = 1'b1;
    localparam int   HN   = DEB + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] btn = 8'h00;
    logic       strobe = 1'b0;
    logic       read = 1'b0;
    logic       o_data;
    logic [7:0] o_btn_stable;
    logic [3:0] o_read_count;

    int n_checks = 0;
    int n_fail   = 0;

    usbh_nes_joypad_serializer #(
        .c_debounce_cycles(DEB),
        .c_fill_bit(FILL)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_btn(btn),
        .i_strobe(strobe),
        .i_read(read),
        .o_data(o_data),
        .o_btn_stable(o_btn_stable),
        .o_read_count(o_read_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] clean_m(input logic [7:0] b);
        logic [7:0] r;
        r = b;
`ifdef JOYPAD_DPAD_CLEAN_EN
        if (b[4] && b[5]) begin
            r[4] = 1'b0;
            r[5] = 1'b0;
        end
        if (b[6] && b[7]) begin
            r[6] = 1'b0;
            r[7] = 1'b0;
        end
`endif
        return r;
    endfunction

    // Reference model: a button value is accepted once DEB+1 consecutive samples,
    // ending two samples back (synchroniser delay), all agree.
    logic [7:0] hist [HN];
    logic [7:0] stable_m;
    logic [7:0] latched_m;
    int         reads_m;

    function automatic logic window_eq(input logic [7:0] h [HN]);
        for (int i = 2; i <= DEB + 1; i++)
            if (h[i] != h[1]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HN; i++) hist[i] <= 8'h00;
            stable_m  <= 8'h00;
            latched_m <= 8'h00;
            reads_m   <= 0;
        end else begin
            if (strobe) begin
                latched_m <= clean_m(stable_m);
                reads_m   <= 0;
            end else if (read) begin
                reads_m <= (reads_m >= 9) ? 9 : reads_m + 1;
            end
            hist[0] <= btn;
            for (int i = 1; i < HN; i++) hist[i] <= hist[i-1];
            if (window_eq(hist)) stable_m <= hist[1];
        end
    end

    function automatic logic exp_data();
        logic [7:0] l;
        l = latched_m;
        return (reads_m < 8) ? l[reads_m] : FILL;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_data", {15'd0, o_data}, {15'd0, exp_data()});
            chk("model_stable", {8'd0, o_btn_stable}, {8'd0, clean_m(stable_m)});
            chk("model_count", {12'd0, o_read_count}, 16'((reads_m > 8) ? 8 : reads_m));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Latch with one strobe-high cycle, then perform n reads; returns the bits the CPU sampled.
    task automatic strobe_and_read(input int n, output logic [15:0] bits);
        bits = '0;
        @(negedge clk);
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        for (int i = 0; i < n; i++) begin
            read = 1'b1;
            #1 bits[i] = o_data;
            @(negedge clk);
        end
        read = 1'b0;
    endtask

    task automatic do_reads(input int n, output logic [15:0] bits);
        bits = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            read = 1'b1;
            #1 bits[i] = o_data;
        end
        @(negedge clk);
        read = 1'b0;
    endtask

    initial begin
        logic [15:0] bits;

        // Reset state
        cycles(3);
        #1;
        chk("rst_data", {15'd0, o_data}, 16'd0);
        chk("rst_count", {12'd0, o_read_count}, 16'd0);
        chk("rst_stable", {8'd0, o_btn_stable}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        cycles(5);
        chk("idle_data", {15'd0, o_data}, 16'd0);
        chk("idle_stable", {8'd0, o_btn_stable}, 16'd0);

        // A + Start, ten reads
        btn = 8'h09;
        cycles(70);
        chk("ast_stable", {8'd0, o_btn_stable}, 16'h0009);
        strobe_and_read(10, bits);
        chk("ast_seq", bits, 16'b0000_0011_0000_1001);
        chk("ast_count", {12'd0, o_read_count}, 16'd8);

        // Glitch on bit1 shorter than the debounce window
        for (int i = 0; i < 10; i++) begin
            btn = btn ^ 8'h02;
            @(negedge clk);
        end
        btn = 8'h09;
        cycles(80);
        chk("glitch_stable", {8'd0, o_btn_stable}, 16'h0009);

        // Held change: accepted exactly 67 edges later
        btn = 8'h0B;
        for (int k = 1; k <= 67; k++) begin
            @(posedge clk);
            #1;
            if (k == 66) chk("lat66", {15'd0, o_btn_stable[1]}, 16'd0);
            if (k == 67) chk("lat67", {15'd0, o_btn_stable[1]}, 16'd1);
        end
        cycles(40);

        // Strobe held high ignores reads
        strobe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            read = 1'b1;
            @(negedge clk);
            read = 1'b0;
            chk("hold_data", {15'd0, o_data}, 16'd1);
            chk("hold_count", {12'd0, o_read_count}, 16'd0);
        end
        strobe = 1'b0;
        do_reads(3, bits);
        chk("pre_both_count", {12'd0, o_read_count}, 16'd3);
        strobe = 1'b1;
        read   = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        read   = 1'b0;
        chk("both_count", {12'd0, o_read_count}, 16'd0);
        chk("both_data", {15'd0, o_data}, 16'd1);

        // Buttons changing after the strobe stay invisible
        btn = 8'h5B;
        cycles(70);
        strobe_and_read(4, bits);
        chk("old_first4", bits, 16'h000B);
        btn = 8'hA4;
        cycles(70);
        do_reads(4, bits);
        chk("old_last4", bits, 16'h0005);

        // Reset asserted in the middle of a read cycle
        strobe_and_read(4, bits);
        @(negedge clk);
        read = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_data", {15'd0, o_data}, 16'd0);
        chk("arst_count", {12'd0, o_read_count}, 16'd0);
        @(negedge clk);
        read = 1'b0;
        rst  = 1'b0;
        do_reads(2, bits);
        chk("post_rst_reads", bits, 16'h0000);

        // All directions pressed
        btn = 8'hF0;
        cycles(70);
        strobe_and_read(8, bits);
`ifdef JOYPAD_DPAD_CLEAN_EN
        chk("dpad_bits", bits, 16'h0000);
`else
        chk("dpad_bits", bits, 16'h00F0);
`endif

        // Randomised traffic
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 799) == 0);
            if (((i / 500) % 2) == 0) begin
                if ($urandom_range(0, 24) == 0) btn = 8'($urandom);
            end else begin
                if ($urandom_range(0, 149) == 0) btn = 8'($urandom);
            end
            strobe = ($urandom_range(0, 11) == 0);
            read   = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        rst    = 1'b0;
        strobe = 1'b0;
        read   = 1'b0;
        cycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
